// File: rtl/vmicro16_cluster_arb.sv
// Vmicro16 cluster APB interconnect: round-robin arbitration of NCORES core masters,
// a local scratch RAM window, and an external APB master port with a stall timeout.
module vmicro16_cluster_arb #(
  parameter int BUS_WIDTH   = 16,
  parameter int DATA_WIDTH  = 16,
  parameter int NCORES      = 4,
  parameter int ADDR_MSB    = 15,
  parameter int ADDR_LSB    = 12,
  parameter int LOCAL_SEL   = 1,
  parameter int LOCAL_WORDS = 64,
  parameter int TIMEOUT     = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NCORES*BUS_WIDTH-1:0]  S_PADDR,
  input  logic [NCORES-1:0]            S_PWRITE,
  input  logic [NCORES-1:0]            S_PSELx,
  input  logic [NCORES-1:0]            S_PENABLE,
  input  logic [NCORES*DATA_WIDTH-1:0] S_PWDATA,
  output logic [NCORES*DATA_WIDTH-1:0] S_PRDATA,
  output logic [NCORES-1:0]            S_PREADY,
  output logic [NCORES-1:0]            S_PSLVERR,
  output logic [BUS_WIDTH-1:0]         M_PADDR,
  output logic                         M_PWRITE,
  output logic                         M_PSELx,
  output logic                         M_PENABLE,
  output logic [DATA_WIDTH-1:0]        M_PWDATA,
  input  logic [DATA_WIDTH-1:0]        M_PRDATA,
  input  logic                         M_PREADY
);

  localparam int GW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int AW = (LOCAL_WORDS > 1) ? $clog2(LOCAL_WORDS) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int FW = ADDR_MSB - ADDR_LSB + 1;
  localparam logic [FW-1:0] SEL_VAL = FW'(LOCAL_SEL);
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {IDLE, LOCAL, SETUP, ACCESS, RESP} state_t;

  state_t                  state;
  logic [GW-1:0]           last_grant;
  logic [GW-1:0]           lat_grant;
  logic [BUS_WIDTH-1:0]    lat_addr;
  logic                    lat_write;
  logic [DATA_WIDTH-1:0]   lat_wdata;
  logic [CW-1:0]           wait_cnt;
  logic                    m_sel;
  logic                    m_en;
  logic                    resp_valid;
  logic                    resp_err;
  logic [DATA_WIDTH-1:0]   resp_data;

  logic [GW-1:0]           pick;
  logic [BUS_WIDTH-1:0]    req_addr;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic [AW-1:0]           ram_idx;
  logic [DATA_WIDTH-1:0]   mem [LOCAL_WORDS];

  logic                    unused_penable;
  assign unused_penable = ^S_PENABLE;

  // Scan downwards so the lowest offset from last+1 is the final (winning) overwrite.
  function automatic logic [GW-1:0] rr_pick(input logic [GW-1:0] last,
                                            input logic [NCORES-1:0] req);
    logic [GW-1:0] sel;
    int unsigned   cand;
    sel = last;
    for (int unsigned i = NCORES; i >= 1; i--) begin
      cand = (32'(last) + i) % NCORES;
      if (req[cand[GW-1:0]]) sel = cand[GW-1:0];
    end
    return sel;
  endfunction

  always_comb begin
    pick      = rr_pick(last_grant, S_PSELx);
    req_addr  = S_PADDR[pick*BUS_WIDTH +: BUS_WIDTH];
    req_wdata = S_PWDATA[pick*DATA_WIDTH +: DATA_WIDTH];
  end

  assign ram_idx   = lat_addr[AW-1:0];
  assign M_PADDR   = lat_addr;
  assign M_PWRITE  = lat_write;
  assign M_PWDATA  = lat_wdata;
  assign M_PSELx   = m_sel;
  assign M_PENABLE = m_en;

  // Scratch RAM is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (state == LOCAL && lat_write) mem[ram_idx] <= lat_wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= GW'(NCORES - 1);
      lat_grant  <= '0;
      lat_addr   <= '0;
      lat_write  <= 1'b0;
      lat_wdata  <= '0;
      wait_cnt   <= '0;
      m_sel      <= 1'b0;
      m_en       <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|S_PSELx) begin
            lat_grant  <= pick;
            last_grant <= pick;
            lat_addr   <= req_addr;
            lat_write  <= S_PWRITE[pick];
            lat_wdata  <= req_wdata;
            if (req_addr[ADDR_MSB:ADDR_LSB] == SEL_VAL) begin
              state <= LOCAL;
            end else begin
              state <= SETUP;
              m_sel <= 1'b1;
            end
          end
        end
        LOCAL: begin
          resp_data  <= lat_write ? '0 : mem[ram_idx];
          resp_err   <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        SETUP: begin
          m_en     <= 1'b1;
          wait_cnt <= '0;
          state    <= ACCESS;
        end
        ACCESS: begin
          if (M_PREADY) begin
            m_sel      <= 1'b0;
            m_en       <= 1'b0;
            resp_data  <= lat_write ? '0 : M_PRDATA;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (TIMEOUT != 0 && wait_cnt == TO_LAST) begin
            m_sel      <= 1'b0;
            m_en       <= 1'b0;
            resp_data  <= lat_write ? '0 : '1;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_data  <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    S_PREADY  = '0;
    S_PSLVERR = '0;
    S_PRDATA  = '0;
    if (resp_valid) begin
      S_PREADY[lat_grant]                          = 1'b1;
      S_PSLVERR[lat_grant]                         = resp_err;
      S_PRDATA[lat_grant*DATA_WIDTH +: DATA_WIDTH] = resp_data;
    end
  end

endmodule

// File: tb/tb_vmicro16_cluster_arb.sv
// Scoreboard bench for vmicro16_cluster_arb: expected responses are queued at issue
// and a negedge monitor checks each S_PREADY pulse against the queue head.
module tb_vmicro16_cluster_arb;

  localparam int NC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [63:0]   S_PADDR = '0;
  logic [3:0]    S_PWRITE = '0;
  logic [3:0]    S_PSELx = '0;
  logic [3:0]    S_PENABLE = '0;
  logic [63:0]   S_PWDATA = '0;
  logic [63:0]   S_PRDATA;
  logic [3:0]    S_PREADY;
  logic [3:0]    S_PSLVERR;
  logic [15:0]   M_PADDR;
  logic          M_PWRITE;
  logic          M_PSELx;
  logic          M_PENABLE;
  logic [15:0]   M_PWDATA;
  logic [15:0]   M_PRDATA = '0;
  logic          M_PREADY = 1'b0;

  vmicro16_cluster_arb #(
    .BUS_WIDTH(16), .DATA_WIDTH(16), .NCORES(NC), .ADDR_MSB(15), .ADDR_LSB(12),
    .LOCAL_SEL(1), .LOCAL_WORDS(64), .TIMEOUT(8)
  ) dut (
    .clk(clk), .reset(reset),
    .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx), .S_PENABLE(S_PENABLE),
    .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY), .S_PSLVERR(S_PSLVERR),
    .M_PADDR(M_PADDR), .M_PWRITE(M_PWRITE), .M_PSELx(M_PSELx), .M_PENABLE(M_PENABLE),
    .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA), .M_PREADY(M_PREADY)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    int          core;
    logic [15:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_miss = 0;

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h required %h", nm, got, exp);
    end
  endtask

  // External slave: ready after slave_waits ACCESS cycles unless slave_never.
  int          slave_waits = 0;
  bit          slave_never = 1'b0;
  logic [15:0] slave_data = '0;
  int          acc = 0;
  int          setup_cyc = -1;
  int          access_cyc = -1;
  logic [15:0] acc_addr = '0;
  bit          m_sel_seen = 1'b0;

  always @(negedge clk) begin
    if (M_PSELx) m_sel_seen = 1'b1;
    if (M_PSELx && !M_PENABLE && setup_cyc < 0) setup_cyc = cyc;
    if (M_PSELx && M_PENABLE) begin
      if (access_cyc < 0) begin
        access_cyc = cyc;
        acc_addr   = M_PADDR;
      end
      M_PREADY = !slave_never && (acc == slave_waits);
      M_PRDATA = M_PREADY ? slave_data : 16'h0;
      acc++;
    end else begin
      acc      = 0;
      M_PREADY = 1'b0;
      M_PRDATA = 16'h0;
    end
  end

  exp_t        me;
  logic [3:0]  exp_rdy;
  logic [3:0]  exp_err;
  logic [63:0] exp_rd;

  always @(negedge clk) begin
    if (reset && S_PREADY != 4'b0) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_resp: got S_PREADY=%b required none", S_PREADY);
      end else begin
        me = sb.pop_front();
        exp_rdy = '0; exp_rdy[me.core] = 1'b1;
        exp_err = '0; exp_err[me.core] = me.err;
        exp_rd  = '0; exp_rd[me.core*16 +: 16] = me.data;
        if (S_PREADY !== exp_rdy || S_PSLVERR !== exp_err || S_PRDATA !== exp_rd ||
            (me.cyc >= 0 && cyc != me.cyc)) begin
          n_miss++;
          $display("FAIL resp_core%0d: got rdy=%b err=%b rdata=%h cyc=%0d required rdy=%b err=%b rdata=%h cyc=%0d",
                   me.core, S_PREADY, S_PSLVERR, S_PRDATA, cyc, exp_rdy, exp_err, exp_rd, me.cyc);
        end
      end
    end
  end

  // One core transfer: request held until S_PREADY; b2b re-requests in the response cycle.
  task automatic xfer(input int c, input logic [15:0] a, input logic w, input logic [15:0] d,
                      input logic [15:0] ed, input logic ee, input int lat,
                      input bit push, input bit b2b);
    exp_t e;
    bit   got;
    if (push) begin
      e.core = c; e.data = ed; e.err = ee; e.cyc = (lat < 0) ? -1 : cyc + lat;
      sb.push_back(e);
    end
    S_PADDR[c*16 +: 16]  = a;
    S_PWDATA[c*16 +: 16] = d;
    S_PWRITE[c]  = w;
    S_PSELx[c]   = 1'b1;
    S_PENABLE[c] = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      got = S_PREADY[c];
    end
    S_PSELx[c]   = 1'b0;
    S_PENABLE[c] = 1'b0;
    if (!got) begin
      n_vec++;
      n_miss++;
      $display("FAIL xfer_wait core%0d: S_PREADY not seen, required within 60 cycles", c);
    end
    if (!b2b) @(negedge clk);
  endtask

  task automatic rr_core(input int c, input int reps);
    for (int k = 0; k < reps; k++)
      xfer(c, 16'h1010 + 16'(c), 1'b0, 16'h0, 16'h0, 1'b0, -1, 1'b0, 1'b1);
  endtask

  exp_t pe;
  int   t0;
  bit   got_acc;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_m_outputs", 64'({M_PSELx, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA}), 64'h0);
    check("reset_s_flags", 64'({S_PREADY, S_PSLVERR}), 64'h0);
    check("reset_s_prdata", S_PRDATA, 64'h0);
    reset = 1'b1;
    @(negedge clk);

    // Local write then read by core 0.
    m_sel_seen = 1'b0;
    xfer(0, 16'h1005, 1'b1, 16'hBEEF, 16'h0000, 1'b0, 2, 1'b1, 1'b0);
    xfer(0, 16'h1005, 1'b0, 16'h0000, 16'hBEEF, 1'b0, 2, 1'b1, 1'b0);
    check("local_no_msel", 64'(m_sel_seen), 64'h0);

    // Preload round-robin words via core 3 (leaves last_grant = 3).
    for (int c = 0; c < NC; c++)
      xfer(3, 16'h1010 + 16'(c), 1'b1, 16'hA000 + 16'(c), 16'h0000, 1'b0, 2, 1'b1, 1'b0);

    // All cores request at once; expected order 0,1,2,3,0,1.
    for (int k = 0; k < 6; k++) begin
      pe.core = k % NC; pe.data = 16'hA000 + 16'(k % NC); pe.err = 1'b0; pe.cyc = -1;
      sb.push_back(pe);
    end
    fork
      rr_core(0, 2);
      rr_core(1, 2);
      rr_core(2, 1);
      rr_core(3, 1);
    join
    @(negedge clk);

    // External read by core 2, three wait states.
    slave_waits = 3; slave_never = 1'b0; slave_data = 16'h1234;
    setup_cyc = -1; access_cyc = -1;
    t0 = cyc;
    xfer(2, 16'h0040, 1'b0, 16'h0, 16'h1234, 1'b0, 6, 1'b1, 1'b0);
    check("ext_setup_cycle", 64'(setup_cyc - t0), 64'd1);
    check("ext_access_cycle", 64'(access_cyc - t0), 64'd2);
    check("ext_paddr", 64'(acc_addr), 64'h0040);

    // Timeout: slave never ready, TIMEOUT=8 -> response at cycle 10.
    slave_never = 1'b1;
    xfer(1, 16'h0080, 1'b0, 16'h0, 16'hFFFF, 1'b1, 10, 1'b1, 1'b0);
    check("timeout_msel_dropped", 64'({M_PSELx, M_PENABLE}), 64'h0);

    // Reset while in ACCESS.
    S_PADDR[2*16 +: 16] = 16'h0050;
    S_PWRITE[2] = 1'b0;
    S_PSELx[2]  = 1'b1;
    got_acc = 1'b0;
    for (int i = 0; i < 20 && !got_acc; i++) begin
      @(negedge clk);
      got_acc = M_PENABLE;
    end
    check("reset_test_reached_access", 64'(got_acc), 64'h1);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 check("async_reset_msel", 64'({M_PSELx, M_PENABLE, S_PREADY}), 64'h0);
    S_PSELx[2] = 1'b0;
    @(negedge clk);
    check("reset_mid_m_outputs", 64'({M_PSELx, M_PENABLE, M_PWRITE, M_PADDR, M_PWDATA}), 64'h0);
    check("reset_mid_s_outputs", 64'({S_PREADY, S_PSLVERR}) | S_PRDATA, 64'h0);
    slave_never = 1'b0;
    reset = 1'b1;

    // After reset core 0 wins over core 2; RAM content survives reset.
    pe.core = 0; pe.data = 16'hBEEF; pe.err = 1'b0; pe.cyc = cyc + 2;
    sb.push_back(pe);
    pe.core = 2; pe.data = 16'hA002; pe.err = 1'b0; pe.cyc = -1;
    sb.push_back(pe);
    fork
      xfer(0, 16'h1005, 1'b0, 16'h0, 16'h0, 1'b0, -1, 1'b0, 1'b1);
      xfer(2, 16'h1012, 1'b0, 16'h0, 16'h0, 1'b0, -1, 1'b0, 1'b1);
    join
    repeat (4) @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss + 1);
    $fatal(1);
  end

endmodule
